pe_out_drain: RTL and testbench

Downstream stage of the PE array. It captures one bank of `X_DIM` signed 16-bit PE outputs in a single cycle, then requantizes each value to `DATA_WIDTH` bits (optional ReLU, arithmetic right shift, saturation). It serializes the results over a valid/ready write port into the output feature-map buffer, with an auto-incrementing address counter.

---
 rtl/pe_out_drain.sv | 135 +++++++++++++
 tb/tb_pe_out_drain.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_out_drain.sv
// pe_out_drain
//   Drains one captured bank of X_DIM signed PE results into the output
//   feature-map buffer. Every word is requantized on the way out: optional
//   ReLU, an arithmetic right shift, then saturation to DATA_WIDTH bits.
//   Writes go out one word per handshake, and an address counter advances
//   with each accepted write.
// Ports
//   clk, rst              clock and synchronous active-high reset
//   frame_start/base_addr reload the address counter (honoured in IDLE only)
//   cap_valid/cap_ready   capture handshake for the pe_out bank
//   pe_out                X_DIM signed 2*DATA_WIDTH-bit PE results
//   relu_en, shift        requant controls, sampled at capture
//   wr_valid/wr_ready     write handshake toward the output buffer
//   wr_addr, wr_data      write address and requantized word
//   busy                  high while draining
//   done                  one-cycle pulse in the first IDLE cycle after the last write
module pe_out_drain #(
  parameter int X_DIM      = 15,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic                          cap_valid,
  output logic                          cap_ready,
  input  logic signed [2*DATA_WIDTH-1:0] pe_out [X_DIM],
  input  logic                          relu_en,
  input  logic [3:0]                    shift,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          busy,
  output logic                          done
);

  localparam int PW   = 2 * DATA_WIDTH;
  localparam int IDXW = (X_DIM > 1) ? $clog2(X_DIM) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(X_DIM - 1);

  localparam logic signed [PW-1:0] UMAX = PW'((1 << DATA_WIDTH) - 1);
  localparam logic signed [PW-1:0] SMAX = PW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SMIN = PW'(-(1 << (DATA_WIDTH - 1)));

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   done_q, done_d;
  logic                   relu_q;
  logic [3:0]             shift_q;
  logic signed [PW-1:0]   buf_q [X_DIM];
  logic                   cap_en;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    cap_en  = 1'b0;
    case (state_q)
      IDLE: begin
        // A reload in the same cycle as a capture lands the first word on base_addr.
        if (frame_start) addr_d = base_addr;
        if (cap_valid) begin
          cap_en  = 1'b1;
          state_d = DRAIN;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        if (wr_ready) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (idx_q == LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      relu_q  <= 1'b0;
      shift_q <= '0;
      for (int i = 0; i < X_DIM; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      if (cap_en) begin
        relu_q  <= relu_en;
        shift_q <= shift;
        for (int i = 0; i < X_DIM; i++) buf_q[i] <= pe_out[i];
      end
    end
  end

  // Requantization, fed only from registered state.
  logic signed [PW-1:0] qv, qs;
  always_comb begin
    qv = buf_q[idx_q];
    if (relu_q && qv < 0) qv = '0;
    qs = qv >>> shift_q;
    wr_data = qs[DATA_WIDTH-1:0];
    if (relu_q) begin
      // qs is non-negative here, so only the upper bound can trip.
      if (qs > UMAX) wr_data = '1;
    end else begin
      if (qs > SMAX)      wr_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (qs < SMIN) wr_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  assign cap_ready = (state_q == IDLE);
  assign wr_valid  = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign wr_addr   = addr_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pe_out_drain.sv
module tb_pe_out_drain;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic [9:0]        base_addr;
  logic              cap_valid;
  logic              cap_ready;
  logic signed [15:0] pe_out [15];
  logic              relu_en;
  logic [3:0]        shift;
  logic              wr_valid;
  logic              wr_ready;
  logic [9:0]        wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_addr;

  always #5 clk = ~clk;

  pe_out_drain #(.X_DIM(15), .DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .base_addr(base_addr),
    .cap_valid(cap_valid), .cap_ready(cap_ready), .pe_out(pe_out),
    .relu_en(relu_en), .shift(shift), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {wr_valid, busy, cap_ready, done, wr_addr, wr_data}
  task automatic test_reset();
    rst = 1'b1; frame_start = 0; base_addr = 0; cap_valid = 0;
    relu_en = 0; shift = 0; wr_ready = 0;
    for (int i = 0; i < 15; i++) pe_out[i] = 16'sd0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({wr_valid, busy, cap_ready, done, wr_addr, wr_data} !== {4'b0010, 10'h000, 8'h00}) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h",
               {wr_valid, busy, cap_ready, done, wr_addr, wr_data}, {4'b0010, 10'h000, 8'h00});
    end
    tick();
    total++;
    if ({wr_valid, busy, cap_ready, done} !== 4'b0010) begin
      bad++;
      $display("FAIL reset_idle_hold got=%b exp=0010", {wr_valid, busy, cap_ready, done});
    end
  endtask

  task automatic test_basic();
    frame_start = 1; base_addr = 10'h010;
    tick();
    frame_start = 0;
    for (int i = 0; i < 15; i++) pe_out[i] = 16'(i * 16);
    shift = 4'd2; relu_en = 0; wr_ready = 1; cap_valid = 1;
    tick();
    cap_valid = 0;
    for (int i = 0; i < 15; i++) begin
      total++;
      if ({wr_valid, busy, cap_ready, done, wr_addr, wr_data} !== {4'b1100, 10'(16 + i), 8'(i * 4)}) begin
        bad++;
        $display("FAIL basic_word[%0d] got=%h exp=%h", i,
                 {wr_valid, busy, cap_ready, done, wr_addr, wr_data}, {4'b1100, 10'(16 + i), 8'(i * 4)});
      end
      tick();
    end
    total++;
    if ({wr_valid, busy, cap_ready, done} !== 4'b0011) begin
      bad++;
      $display("FAIL basic_done got=%b exp=0011", {wr_valid, busy, cap_ready, done});
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL basic_done_width got=%b exp=0", done);
    end
    exp_addr = 10'h01F;
  endtask

  task automatic test_relu_sat();
    logic [7:0] exp_t [3][4];
    logic       relu_t [3];
    logic [3:0] shift_t [3];
    logic [7:0] e;
    exp_t[0] = '{8'h00, 8'hFF, 8'h7F, 8'h00};  // relu, shift 0
    exp_t[1] = '{8'h80, 8'h7F, 8'h7F, 8'hFB};  // signed, shift 0
    exp_t[2] = '{8'hDA, 8'h7D, 8'h0F, 8'hFF};  // signed, shift 3
    relu_t  = '{1'b1, 1'b0, 1'b0};
    shift_t = '{4'd0, 4'd0, 4'd3};
    for (int i = 0; i < 15; i++) pe_out[i] = 16'sd0;
    pe_out[0] = -16'sd300; pe_out[1] = 16'sd1000; pe_out[2] = 16'sd127; pe_out[3] = -16'sd5;
    wr_ready = 1;
    for (int c = 0; c < 3; c++) begin
      relu_en = relu_t[c]; shift = shift_t[c]; cap_valid = 1;
      tick();
      cap_valid = 0;
      for (int i = 0; i < 15; i++) begin
        e = (i < 4) ? exp_t[c][i] : 8'h00;
        total++;
        if ({wr_valid, wr_addr, wr_data} !== {1'b1, exp_addr, e}) begin
          bad++;
          $display("FAIL relu_sat[%0d][%0d] got=%h exp=%h", c, i,
                   {wr_valid, wr_addr, wr_data}, {1'b1, exp_addr, e});
        end
        exp_addr++;
        tick();
      end
      total++;
      if ({wr_valid, cap_ready, done} !== 3'b011) begin
        bad++;
        $display("FAIL relu_sat_done[%0d] got=%b exp=011", c, {wr_valid, cap_ready, done});
      end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int c = 0;
    for (int i = 0; i < 15; i++) pe_out[i] = 16'(100 + i);
    relu_en = 0; shift = 0; wr_ready = 0; cap_valid = 1;
    tick();
    cap_valid = 0;
    while (n < 15 && c < 100) begin
      wr_ready = (c % 4 == 0) || (c % 4 == 3);
      total++;
      if ({wr_valid, done, wr_addr, wr_data} !== {2'b10, exp_addr, 8'(100 + n)}) begin
        bad++;
        $display("FAIL bp_word[%0d] cyc=%0d got=%h exp=%h", n, c,
                 {wr_valid, done, wr_addr, wr_data}, {2'b10, exp_addr, 8'(100 + n)});
      end
      if (wr_ready) begin
        n++;
        exp_addr++;
      end
      tick();
      c++;
    end
    total++;
    if (n != 15) begin
      bad++;
      $display("FAIL bp_timeout accepted=%0d exp=15", n);
    end
    total++;
    if ({wr_valid, cap_ready, done} !== 3'b011) begin
      bad++;
      $display("FAIL bp_done got=%b exp=011", {wr_valid, cap_ready, done});
    end
    wr_ready = 1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 15; i++) pe_out[i] = 16'(i);
    relu_en = 0; shift = 0; wr_ready = 1; cap_valid = 1;
    tick();
    cap_valid = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) begin
        // Second bank presented while still draining; must wait for IDLE.
        for (int k = 0; k < 15; k++) pe_out[k] = 16'(50 + k);
        cap_valid = 1;
      end
      total++;
      if ({wr_valid, wr_addr, wr_data} !== {1'b1, exp_addr, 8'(i)}) begin
        bad++;
        $display("FAIL b2b_a[%0d] got=%h exp=%h", i, {wr_valid, wr_addr, wr_data}, {1'b1, exp_addr, 8'(i)});
      end
      exp_addr++;
      tick();
    end
    total++;
    if ({wr_valid, cap_ready, done} !== 3'b011) begin
      bad++;
      $display("FAIL b2b_done_a got=%b exp=011", {wr_valid, cap_ready, done});
    end
    tick();
    cap_valid = 0;
    for (int i = 0; i < 15; i++) begin
      total++;
      if ({wr_valid, wr_addr, wr_data} !== {1'b1, exp_addr, 8'(50 + i)}) begin
        bad++;
        $display("FAIL b2b_b[%0d] got=%h exp=%h", i, {wr_valid, wr_addr, wr_data}, {1'b1, exp_addr, 8'(50 + i)});
      end
      exp_addr++;
      tick();
    end
    total++;
    if ({wr_valid, cap_ready, done} !== 3'b011) begin
      bad++;
      $display("FAIL b2b_done_b got=%b exp=011", {wr_valid, cap_ready, done});
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 15; i++) pe_out[i] = 16'(i * 3);
    relu_en = 0; shift = 0; wr_ready = 1;
    frame_start = 1; base_addr = 10'h3FA; cap_valid = 1;
    tick();
    frame_start = 0; cap_valid = 0;
    exp_addr = 10'h3FA;
    for (int i = 0; i < 15; i++) begin
      // A reload request mid-drain must be ignored.
      frame_start = (i == 2); base_addr = 10'h100;
      total++;
      if ({wr_valid, wr_addr, wr_data} !== {1'b1, exp_addr, 8'(i * 3)}) begin
        bad++;
        $display("FAIL wrap[%0d] got=%h exp=%h", i, {wr_valid, wr_addr, wr_data}, {1'b1, exp_addr, 8'(i * 3)});
      end
      exp_addr++;
      tick();
    end
    frame_start = 0;
    total++;
    if ({wr_valid, done, wr_addr} !== {2'b01, 10'h009}) begin
      bad++;
      $display("FAIL wrap_end got=%h exp=%h", {wr_valid, done, wr_addr}, {2'b01, 10'h009});
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 15; i++) pe_out[i] = 16'(i + 1);
    relu_en = 0; shift = 0; wr_ready = 1; cap_valid = 1;
    tick();
    cap_valid = 0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    total++;
    if ({wr_valid, busy, cap_ready, done, wr_addr, wr_data} !== {4'b0010, 10'h000, 8'h00}) begin
      bad++;
      $display("FAIL rst_mid got=%h exp=%h",
               {wr_valid, busy, cap_ready, done, wr_addr, wr_data}, {4'b0010, 10'h000, 8'h00});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({wr_valid, done} !== 2'b00) begin
        bad++;
        $display("FAIL rst_no_done[%0d] got=%b exp=00", i, {wr_valid, done});
      end
    end
    cap_valid = 1;
    tick();
    cap_valid = 0;
    for (int i = 0; i < 15; i++) begin
      total++;
      if ({wr_valid, wr_addr, wr_data} !== {1'b1, 10'(i), 8'(i + 1)}) begin
        bad++;
        $display("FAIL rst_redrain[%0d] got=%h exp=%h", i, {wr_valid, wr_addr, wr_data}, {1'b1, 10'(i), 8'(i + 1)});
      end
      tick();
    end
    total++;
    if ({wr_valid, cap_ready, done} !== 3'b011) begin
      bad++;
      $display("FAIL rst_redrain_done got=%b exp=011", {wr_valid, cap_ready, done});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu_sat();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
